// File: rtl/cpu_ifetch_unit.sv
// Instruction fetch stage: program counter plus a direct-mapped read-only cache
// filled in 128-bit blocks over the memory controller request/response structs.
package mci_pkg;
  typedef struct packed {
    logic         valid;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } mci_request_t;

  typedef struct packed {
    logic         ready;
    logic [127:0] data;
  } mci_response_t;
endpackage

// Handshakes: o_done qualifies o_pc/o_instruction and the pair is consumed on a
// cycle where o_done && i_pipeline_ready; mem_req.valid is a one-cycle request
// pulse, and the single outstanding request completes on the first mem_res.ready.
module cpu_ifetch_unit #(
  parameter int          CACHE_LINES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  output mci_pkg::mci_request_t  mem_req,
  input  mci_pkg::mci_response_t mem_res,
  input  logic                   i_pipeline_ready,
  output logic                   o_done,
  input  logic                   i_ext_pc_load,
  input  logic [31:0]            i_ext_pc,
  output logic [31:0]            o_pc,
  output logic [31:0]            o_instruction,
  output logic [1:0]             dbg_state
);

  localparam int IDXW = $clog2(CACHE_LINES);
  localparam int TAGW = 32 - IDXW - 4;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]            pc;
  logic [CACHE_LINES-1:0] line_valid;
  logic [TAGW-1:0]        line_tag  [CACHE_LINES];
  logic [127:0]           line_data [CACHE_LINES];

  logic [IDXW-1:0] pc_idx;
  logic [TAGW-1:0] pc_tag;
  logic [1:0]      pc_off;
  logic [1:0]      unused_pc_low;
  logic            hit;
  logic            fill;

  assign pc_idx        = pc[IDXW+3:4];
  assign pc_tag        = pc[31:IDXW+4];
  assign pc_off        = pc[3:2];
  assign unused_pc_low = pc[1:0];
  assign hit           = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
  assign fill          = (state == ST_MISS_WAIT) && mem_res.ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= ST_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        // A redirect wins over a miss: the old PC's miss is never requested.
        if (!i_ext_pc_load && !hit) state_nxt = ST_MISS_REQ;
      end
      ST_MISS_REQ:  state_nxt = ST_MISS_WAIT;
      ST_MISS_WAIT: if (mem_res.ready) state_nxt = ST_FETCH;
      default:      state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req.valid = (state == ST_MISS_REQ);
    mem_req.rw    = 1'b0;
    mem_req.addr  = {pc[31:4], 4'b0000};
    mem_req.data  = '0;
    o_done        = (state == ST_FETCH) && hit;
    o_pc          = pc;
    o_instruction = line_data[pc_idx][{pc_off, 5'b00000} +: 32];
    dbg_state     = state;
  end

  // PC only moves in FETCH, so the request address stays stable through a miss.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc <= RESET_PC;
    end else if (state == ST_FETCH) begin
      if (i_ext_pc_load)               pc <= i_ext_pc;
      else if (hit && i_pipeline_ready) pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)  line_valid         <= '0;
    else if (fill) line_valid[pc_idx] <= 1'b1;
  end

  // Tag and data storage need no reset; the valid bits guard them.
  always_ff @(posedge i_clk) begin
    if (fill) begin
      line_tag[pc_idx]  <= pc_tag;
      line_data[pc_idx] <= mem_res.data;
    end
  end

endmodule

// File: tb/tb_cpu_ifetch_unit.sv
// Directed bench for cpu_ifetch_unit: memory block b holds words 4b..4b+3, so the
// instruction fetched at any pc is pc >> 2.
module tb_cpu_ifetch_unit;
  import mci_pkg::*;

  logic          clk;
  logic          rst_n;
  mci_request_t  mem_req;
  mci_response_t mem_res;
  logic          pipe_ready;
  logic          done;
  logic          ext_load;
  logic [31:0]   ext_pc;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int req_count = 0;
  int req_snap;

  cpu_ifetch_unit dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .mem_req          (mem_req),
    .mem_res          (mem_res),
    .i_pipeline_ready (pipe_ready),
    .o_done           (done),
    .i_ext_pc_load    (ext_load),
    .i_ext_pc         (ext_pc),
    .o_pc             (pc),
    .o_instruction    (instr),
    .dbg_state        (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_req.valid) req_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [127:0] block_of(input logic [31:0] a);
    logic [31:0] base;
    logic [127:0] blk;
    base = {2'b00, a[31:4], 2'b00};
    for (int w = 0; w < 4; w++) blk[32*w +: 32] = base + w;
    return blk;
  endfunction

  // Waits for the request pulse, checks it, then answers after lat cycles.
  task automatic serve_miss(input string tag, input logic [31:0] exp_addr, input int lat);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req.valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_req_seen"}, {31'b0, seen}, 32'd1);
    if (!seen) return;
    check({tag, "_req_addr"}, mem_req.addr, exp_addr);
    check({tag, "_req_rw"}, {31'b0, mem_req.rw}, 32'd0);
    @(negedge clk);
    check({tag, "_req_pulse"}, {31'b0, mem_req.valid}, 32'd0);
    check({tag, "_wait_done"}, {31'b0, done}, 32'd0);
    repeat (lat - 1) @(negedge clk);
    mem_res.ready = 1'b1;
    mem_res.data  = block_of(exp_addr);
    @(negedge clk);
    mem_res.ready = 1'b0;
    mem_res.data  = '0;
  endtask

  task automatic advance(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    pipe_ready = 1'b1;
    @(negedge clk);
    pipe_ready = 1'b0;
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_instr"}, instr, exp_instr);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    ext_load = 1'b1;
    ext_pc   = target;
    @(negedge clk);
    ext_load = 1'b0;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_instr"}, instr, exp_instr);
  endtask

  initial begin
    rst_n         = 1'b0;
    mem_res.ready = 1'b0;
    mem_res.data  = '0;
    pipe_ready    = 1'b0;
    ext_load      = 1'b0;
    ext_pc        = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_req_valid", {31'b0, mem_req.valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);

    // Cold start
    rst_n = 1'b1;
    serve_miss("cold", 32'h0, 2);
    check_fetch("cold", 32'h0, 32'h0);

    // Sequential hits, then a miss into the next block
    req_snap = req_count;
    advance("seq4", 32'h4, 32'h1);
    advance("seq8", 32'h8, 32'h2);
    advance("seqc", 32'hC, 32'h3);
    check("seq_no_req", req_count - req_snap, 32'd0);
    pipe_ready = 1'b1;
    @(negedge clk);
    pipe_ready = 1'b0;
    check("seq10_pc", pc, 32'h10);
    check("seq10_miss_done", {31'b0, done}, 32'd0);
    serve_miss("seq10", 32'h10, 1);
    check_fetch("seq10", 32'h10, 32'h4);

    // Redirect held: pc keeps reloading, no request while the load is up
    req_snap = req_count;
    ext_load = 1'b1;
    ext_pc   = 32'h8000;
    repeat (3) @(negedge clk);
    check("rdr_hold_pc", pc, 32'h8000);
    check("rdr_hold_done", {31'b0, done}, 32'd0);
    check("rdr_hold_no_req", req_count - req_snap, 32'd0);
    ext_load = 1'b0;
    serve_miss("rdr", 32'h8000, 4);
    check_fetch("rdr", 32'h8000, 32'h2000);
    req_snap = req_count;
    advance("rdr_next", 32'h8004, 32'h2001);
    check("rdr_next_no_req", req_count - req_snap, 32'd0);

    // Conflict eviction on index 0
    redirect(32'h0);
    check("cf0_miss", {31'b0, done}, 32'd0);
    serve_miss("cf0", 32'h0, 1);
    check_fetch("cf0", 32'h0, 32'h0);
    redirect(32'h400);
    check("cf400_miss", {31'b0, done}, 32'd0);
    serve_miss("cf400", 32'h400, 2);
    check_fetch("cf400", 32'h400, 32'h100);
    redirect(32'h0);
    check("cfback_miss", {31'b0, done}, 32'd0);
    serve_miss("cfback", 32'h0, 1);
    check_fetch("cfback", 32'h0, 32'h0);

    // Redirect onto a resident line hits in the next cycle; no advance without ready
    req_snap = req_count;
    redirect(32'h14);
    check_fetch("hit14", 32'h14, 32'h5);
    repeat (20) @(negedge clk);
    check_fetch("stall", 32'h14, 32'h5);
    check("stall_no_req", req_count - req_snap, 32'd0);

    // PC wrap from the last word of memory back to 0 (block 0 still resident)
    redirect(32'hFFFF_FFFC);
    serve_miss("top", 32'hFFFF_FFF0, 2);
    check_fetch("top", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    req_snap = req_count;
    advance("wrap", 32'h0, 32'h0);
    check("wrap_no_req", req_count - req_snap, 32'd0);

    // Reset in the middle of a miss, then a stale ready that must be ignored
    redirect(32'h20);
    @(negedge clk);
    check("mid_req", {31'b0, mem_req.valid}, 32'd1);
    @(negedge clk);
    check("mid_wait_state", {30'b0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    mem_res.ready = 1'b1;
    mem_res.data  = {4{32'hDEAD_BEEF}};
    check("post_rst_cold", {31'b0, done}, 32'd0);
    @(negedge clk);
    mem_res.ready = 1'b0;
    mem_res.data  = '0;
    serve_miss("post_rst", 32'h0, 3);
    check_fetch("post_rst", 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_ifetch_unit.md
Name: cpu_ifetch_unit

Overview:
- Instruction fetch stage of the RAPID-X CPU core.
- Holds the program counter and a small direct-mapped read-only instruction cache.
- Fills cache lines as 128-bit blocks from main memory through the memory_controller_interface request/response structs.
- Presents one 32-bit instruction and its PC to the decode pipeline under a done/ready handshake; supports an external PC redirect.

Parameters:
- CACHE_LINES, 64: number of direct-mapped lines, one 128-bit block each; must be a power of two.
- RESET_PC, 32'h0000_0000: PC value after reset.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- mem_req  out  mci_request_t  fields: valid, rw, addr[31:0], data[127:0].
- mem_res  in  mci_response_t  fields: ready, data[127:0].
- i_pipeline_ready  in  1  downstream accepts the current instruction.
- o_done  out  1  o_instruction and o_pc are valid.
- i_ext_pc_load  in  1  redirect request.
- i_ext_pc  in  32  redirect target address.
- o_pc  out  32  address of o_instruction.
- o_instruction  out  32  fetched instruction word.

Behaviour:
- Address split with the default parameter: offset = pc[3:2] selects the 32-bit word within a block (word n = block bits [32n+31:32n]); index = pc[9:4]; tag = pc[31:10]. The index width is log2(CACHE_LINES). pc[1:0] is ignored.
- Reset (i_reset low, asynchronous):
  - pc = RESET_PC; all valid bits cleared; state = FETCH.
  - mem_req.valid = 0; o_done = 0.
- Fixed memory request fields: mem_req.rw = 0 and mem_req.data = 0 always; the unit never writes memory.
- State FETCH:
  - hit = valid[index] && tag match. o_done = hit, combinational, in the same cycle.
  - o_instruction = selected word of the line; o_pc = pc.
  - If i_ext_pc_load = 1: pc <= i_ext_pc. This has priority over the handshake; the current instruction is discarded. While the load is held, pc keeps reloading, and o_done reflects lookup of the held target.
  - Else if hit && i_pipeline_ready: pc <= pc + 4, 32-bit wrapping (0xFFFFFFFC goes to 0).
  - Else if miss: go to MISS_REQ.
- State MISS_REQ (exactly one cycle):
  - mem_req.valid = 1 and mem_req.addr = {pc[31:4], 4'b0}.
  - Next state MISS_WAIT.
- State MISS_WAIT:
  - mem_req.valid = 0; mem_req.addr held stable.
  - On mem_res.ready = 1: write mem_res.data into line[index], set tag, set valid, return to FETCH.
  - The hit is then visible in the next cycle.
- o_done = 0 in MISS_REQ and MISS_WAIT.
- i_pipeline_ready and i_ext_pc_load are ignored in MISS_REQ and MISS_WAIT. The fill always completes before any redirect is taken; a redirect still asserted on return to FETCH takes effect then.
- Conflicting addresses (same index, different tag) evict the resident line; there is no write-back.
- Memory latency is arbitrary (at least 1 cycle); the unit waits indefinitely for ready.
- Reset asserted mid-miss aborts the miss. Any later mem_res.ready with no outstanding request is ignored.
- An outstanding request never has valid held for more than one cycle.

Test Plan:
Memory model: block b holds word w = 4b + w, so the instruction at pc equals pc >> 2.
- Cold start: release reset → one mem_req.valid pulse with addr 0x0; after ready, o_done = 1, o_pc = 0x0, o_instruction = 0x00000000.
- Sequential hits: pulse i_pipeline_ready for one cycle at a time → o_pc 0x4/0x8/0xC with instructions 0x1/0x2/0x3 and no memory requests. The next advance to 0x10 misses, requests addr 0x10, then returns 0x00000004.
- Redirect: hold i_ext_pc_load with i_ext_pc = 0x8000 → request addr 0x8000; o_done rises with o_pc 0x8000 and o_instruction 0x00002000. Releasing the load and pulsing ready gives 0x8004 → 0x00002001 as a hit.
- Conflict eviction: fetch 0x0, then redirect to 0x400 (same index 0) → a miss fetching block 0x400. A redirect back to 0x0 misses again and returns 0x0.
- No advance without handshake: hold i_pipeline_ready = 0 for 20 cycles on a hit → pc, o_instruction and o_done are unchanged, and mem_req.valid stays 0.
- Reset mid-miss: assert i_reset during MISS_WAIT → o_done = 0 and pc = 0 immediately. After release the unit re-requests addr 0x0 and ignores the stale ready.
